// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   One requester port of the SRAM arbiter. Each requester gets its own
//   instance of this interface.
//
//   Signals (master = requester side, slave = arbiter side):
//     req     master->slave  access request, held until gnt
//     we      master->slave  byte write enables, 4'b0000 = read
//     addr    master->slave  word address (AW-2 bits)
//     wdata   master->slave  write data
//     lock    master->slave  keep macro ownership after this port's grant
//     gnt     slave->master  access accepted this cycle (combinational)
//     rvalid  slave->master  rdata holds data for the read granted last cycle
//     rdata   slave->master  read data (shared macro read bus)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int AW = 12
);
  logic          req;
  logic [3:0]    we;
  logic [AW-3:0] addr;
  logic [31:0]   wdata;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port, one-cycle-latency SRAM macro between a primary
//   requester (p0, e.g. the AHB SRAM bridge) and a secondary requester
//   (p1, e.g. a DMA engine). One access is granted per cycle; the grant is
//   combinational so an uncontended request completes with zero wait.
//   Read data is the macro output passed straight through, qualified by a
//   registered per-port rvalid one cycle after the read grant.
//
//   Priority: an active lock restricts grants to its owner; otherwise the
//   starvation override (optional) lets p1 ahead; otherwise p0 wins.
//
//   Optional feature macro: SRAM_ARB_STARVE_EN
//     defined   - p1 waiting MAXWAIT cycles is forced ahead of p0
//     undefined - strict fixed priority, MAXWAIT is ignored
//
//   Ports:
//     HCLK       clock, rising edge
//     HRESET     synchronous active-high reset
//     p0, p1     requester ports (sram_port_arbiter_if.slave)
//     SRAMRDATA  macro read data
//     SRAMCS     macro chip select, active high
//     SRAMWEN    macro byte write enables, active high
//     SRAMADDR   macro word address
//     SRAMWDATA  macro write data
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int AW      = 12,
  parameter int MAXWAIT = 4    // 1..15
) (
  input  logic              HCLK,
  input  logic              HRESET,
  sram_port_arbiter_if.slave p0,
  sram_port_arbiter_if.slave p1,
  input  logic [31:0]       SRAMRDATA,
  output logic              SRAMCS,
  output logic [3:0]        SRAMWEN,
  output logic [AW-3:0]     SRAMADDR,
  output logic [31:0]       SRAMWDATA
);

  // Lock owner encoding.
  localparam logic [0:0] OWNER_P0 = 1'b0;
  localparam logic [0:0] OWNER_P1 = 1'b1;

  logic       locked_q, locked_d;
  logic [0:0] owner_q,  owner_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       gnt0, gnt1;
  logic       starve;
  logic       owner_lock;

`ifdef SRAM_ARB_STARVE_EN
  localparam logic [3:0] MAXWAIT_W = 4'(MAXWAIT);
  logic [3:0] wait1_q, wait1_d;
`else
  // MAXWAIT has no function without the starvation counter.
  logic unused_maxwait;
  assign unused_maxwait = ^MAXWAIT;
`endif

  // -------------------------------------------------------------------------
  // Grant decision
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt0   = 1'b0;
    gnt1   = 1'b0;
`ifdef SRAM_ARB_STARVE_EN
    starve = p1.req && (wait1_q == MAXWAIT_W);
`else
    starve = 1'b0;
`endif
    if (locked_q) begin
      // A lock is never broken by the starvation override.
      if (owner_q == OWNER_P1) gnt1 = p1.req;
      else                     gnt0 = p0.req;
    end else if (starve) begin
      gnt1 = 1'b1;
    end else if (p0.req) begin
      gnt0 = 1'b1;
    end else if (p1.req) begin
      gnt1 = 1'b1;
    end
  end

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  // -------------------------------------------------------------------------
  // Macro drive: muxed from the granted port, all-zero when idle
  // -------------------------------------------------------------------------
  always_comb begin
    SRAMCS    = gnt0 | gnt1;
    SRAMWEN   = '0;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    if (gnt0) begin
      SRAMWEN   = p0.we;
      SRAMADDR  = p0.addr;
      SRAMWDATA = p0.wdata;
    end else if (gnt1) begin
      SRAMWEN   = p1.we;
      SRAMADDR  = p1.addr;
      SRAMWDATA = p1.wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign owner_lock = (owner_q == OWNER_P1) ? p1.lock : p0.lock;

  always_comb begin
    rvalid0_d = gnt0 && (p0.we == 4'b0000);
    rvalid1_d = gnt1 && (p1.we == 4'b0000);

    locked_d = locked_q;
    owner_d  = owner_q;
    if (gnt0 && p0.lock) begin
      locked_d = 1'b1;
      owner_d  = OWNER_P0;
    end else if (gnt1 && p1.lock) begin
      locked_d = 1'b1;
      owner_d  = OWNER_P1;
    end else if (locked_q && !owner_lock) begin
      // Owner dropped LOCK (idle or granted): release seen next cycle.
      locked_d = 1'b0;
    end
  end

`ifdef SRAM_ARB_STARVE_EN
  always_comb begin
    wait1_d = wait1_q;
    if (!p1.req || gnt1)          wait1_d = 4'd0;
    else if (wait1_q != MAXWAIT_W) wait1_d = wait1_q + 4'd1;
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every flop samples the pre-edge
  // value of its inputs regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      locked_q  <= 1'b0;
      owner_q   <= OWNER_P0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef SRAM_ARB_STARVE_EN
      wait1_q   <= 4'd0;
`endif
    end else begin
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef SRAM_ARB_STARVE_EN
      wait1_q   <= wait1_d;
`endif
    end
  end

  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.rdata  = SRAMRDATA;
  assign p1.rdata  = SRAMRDATA;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter with a behavioural one-cycle
//   latency SRAM macro. Inputs change 1 ns after the rising edge;
//   combinational outputs are sampled 1 ns later, registered outputs
//   1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int AW      = 12;
  localparam int MAXWAIT = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   SRAMRDATA;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-3:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;

  sram_port_arbiter_if #(.AW(AW)) p0_if ();
  sram_port_arbiter_if #(.AW(AW)) p1_if ();

  sram_port_arbiter #(.AW(AW), .MAXWAIT(MAXWAIT)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .p0        (p0_if),
    .p1        (p1_if),
    .SRAMRDATA (SRAMRDATA),
    .SRAMCS    (SRAMCS),
    .SRAMWEN   (SRAMWEN),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural single-port macro, one-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      else
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    p0_if.req = 1'b0; p0_if.we = 4'h0; p0_if.addr = '0; p0_if.wdata = '0; p0_if.lock = 1'b0;
    p1_if.req = 1'b0; p1_if.we = 4'h0; p1_if.addr = '0; p1_if.wdata = '0; p1_if.lock = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    HRESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    HRESET = 1'b0;
    settle();
    total++; if ({p0_if.rvalid, p1_if.rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {p0_if.rvalid, p1_if.rvalid}); else passed++;
    total++; if ({SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA} !== '0) $display("FAIL reset_sram_idle: cs=%b wen=%h addr=%h wdata=%h want all 0", SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA); else passed++;
    total++; if ({p0_if.gnt, p1_if.gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {p0_if.gnt, p1_if.gnt}); else passed++;
    total++; if (dut.locked_q !== 1'b0) $display("FAIL reset_locked: got %b want 0", dut.locked_q); else passed++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_p0_read;
    p0_if.req = 1'b1; p0_if.we = 4'h0; p0_if.addr = 10'h010;
    settle();
    total++; if ({p0_if.gnt, p1_if.gnt, SRAMCS} !== 3'b101) $display("FAIL p0_read_gnt: gnt0/gnt1/cs got %b want 101", {p0_if.gnt, p1_if.gnt, SRAMCS}); else passed++;
    total++; if (SRAMADDR !== 10'h010) $display("FAIL p0_read_addr: got %h want 010", SRAMADDR); else passed++;
    tick();
    idle_inputs();
    total++; if ({p0_if.rvalid, p1_if.rvalid} !== 2'b10) $display("FAIL p0_read_rvalid: got %b want 10", {p0_if.rvalid, p1_if.rvalid}); else passed++;
    total++; if (p0_if.rdata !== 32'hDEADBEEF) $display("FAIL p0_read_rdata: got %h want deadbeef", p0_if.rdata); else passed++;
    tick();
    total++; if (p0_if.rvalid !== 1'b0) $display("FAIL p0_read_rvalid_drop: got %b want 0", p0_if.rvalid); else passed++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_p1_write;
    p1_if.req = 1'b1; p1_if.we = 4'b0011; p1_if.addr = 10'h020; p1_if.wdata = 32'h12345678;
    settle();
    total++; if ({p1_if.gnt, SRAMCS, SRAMWEN} !== 6'b1_1_0011) $display("FAIL p1_write_cs_wen: gnt1/cs/wen got %b want 110011", {p1_if.gnt, SRAMCS, SRAMWEN}); else passed++;
    total++; if ({SRAMADDR, SRAMWDATA} !== {10'h020, 32'h12345678}) $display("FAIL p1_write_bus: addr=%h wdata=%h want 020/12345678", SRAMADDR, SRAMWDATA); else passed++;
    tick();
    idle_inputs();
    total++; if ({p0_if.rvalid, p1_if.rvalid} !== 2'b00) $display("FAIL p1_write_no_rvalid: got %b want 00", {p0_if.rvalid, p1_if.rvalid}); else passed++;
    // Read back: only the two enabled bytes were written.
    p1_if.req = 1'b1; p1_if.addr = 10'h020;
    tick();
    idle_inputs();
    total++; if ({p1_if.rvalid, p1_if.rdata} !== {1'b1, 32'h00005678}) $display("FAIL p1_readback: rvalid=%b rdata=%h want 1/00005678", p1_if.rvalid, p1_if.rdata); else passed++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_starvation;
    logic exp1;
    p0_if.req = 1'b1; p0_if.addr = 10'h001;
    p1_if.req = 1'b1; p1_if.addr = 10'h002;
    for (int i = 0; i < 10; i++) begin
      settle();
`ifdef SRAM_ARB_STARVE_EN
      exp1 = (i % 5) == 4;
`else
      exp1 = 1'b0;
`endif
      total++; if ({p0_if.gnt, p1_if.gnt} !== {~exp1, exp1}) $display("FAIL starve_cycle%0d: gnt0/gnt1 got %b want %b", i, {p0_if.gnt, p1_if.gnt}, {~exp1, exp1}); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_lock;
    p1_if.req = 1'b1; p1_if.we = 4'hF; p1_if.addr = 10'h030; p1_if.wdata = 32'hA5A5A5A5; p1_if.lock = 1'b1;
    settle();
    total++; if (p1_if.gnt !== 1'b1) $display("FAIL lock_p1_gnt: got %b want 1", p1_if.gnt); else passed++;
    tick();
    p1_if.req = 1'b0;
    p0_if.req = 1'b1; p0_if.we = 4'h0; p0_if.addr = 10'h030;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if ({p0_if.gnt, p1_if.gnt, SRAMCS} !== 3'b000) $display("FAIL lock_hold%0d: gnt0/gnt1/cs got %b want 000", i, {p0_if.gnt, p1_if.gnt, SRAMCS}); else passed++;
      tick();
    end
    p1_if.lock = 1'b0;
    settle();
    total++; if (p0_if.gnt !== 1'b0) $display("FAIL lock_release_cycle: got %b want 0", p0_if.gnt); else passed++;
    tick();
    settle();
    total++; if (p0_if.gnt !== 1'b1) $display("FAIL lock_after_release: got %b want 1", p0_if.gnt); else passed++;
    tick();
    idle_inputs();
    total++; if ({p0_if.rvalid, p0_if.rdata} !== {1'b1, 32'hA5A5A5A5}) $display("FAIL lock_readback: rvalid=%b rdata=%h want 1/a5a5a5a5", p0_if.rvalid, p0_if.rdata); else passed++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid;
    // p0 read with lock, p1 contending, reset on the closing edge.
    p0_if.req = 1'b1; p0_if.we = 4'h0; p0_if.addr = 10'h010; p0_if.lock = 1'b1;
    p1_if.req = 1'b1; p1_if.addr = 10'h010;
    HRESET = 1'b1;
    settle();
    total++; if ({p0_if.gnt, p1_if.gnt} !== 2'b10) $display("FAIL reset_mid_gnt: got %b want 10", {p0_if.gnt, p1_if.gnt}); else passed++;
    tick();
    HRESET = 1'b0;
    p0_if.req = 1'b0;   // lock left high: only a reset-cleared lock lets p1 in
    total++; if (p0_if.rvalid !== 1'b0) $display("FAIL reset_mid_rvalid: got %b want 0", p0_if.rvalid); else passed++;
    total++; if (dut.locked_q !== 1'b0) $display("FAIL reset_mid_locked: got %b want 0", dut.locked_q); else passed++;
`ifdef SRAM_ARB_STARVE_EN
    total++; if (dut.wait1_q !== 4'd0) $display("FAIL reset_mid_wait1: got %0d want 0", dut.wait1_q); else passed++;
`endif
    settle();
    total++; if (p1_if.gnt !== 1'b1) $display("FAIL reset_mid_p1_gnt: got %b want 1", p1_if.gnt); else passed++;
    tick();
    idle_inputs();
    total++; if ({p1_if.rvalid, p1_if.rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL reset_mid_p1_read: rvalid=%b rdata=%h want 1/deadbeef", p1_if.rvalid, p1_if.rdata); else passed++;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_alternate;
    logic        even;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    for (int i = 0; i < 8; i++) begin
      even = (i % 2) == 0;
      idle_inputs();
      if (even) begin
        p0_if.req  = 1'b1;
        p0_if.addr = (i == 0) ? 10'h010 : 10'(10'h040 + i - 1);
        exp_rdata  = (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i - 1);
        exp_wdata  = 32'h0;
      end else begin
        p1_if.req   = 1'b1;
        p1_if.we    = 4'hF;
        p1_if.addr  = 10'(10'h040 + i);
        p1_if.wdata = 32'h1000_0000 + 32'(i);
        exp_wdata   = p1_if.wdata;
      end
      settle();
      total++; if ({p0_if.gnt, p1_if.gnt, SRAMWDATA} !== {even, ~even, exp_wdata}) $display("FAIL alt%0d_gnt_wdata: gnt=%b wdata=%h want %b/%h", i, {p0_if.gnt, p1_if.gnt}, SRAMWDATA, {even, ~even}, exp_wdata); else passed++;
      tick();
      total++; if ({p0_if.rvalid, p1_if.rvalid} !== {even, 1'b0}) $display("FAIL alt%0d_rvalid: got %b want %b", i, {p0_if.rvalid, p1_if.rvalid}, {even, 1'b0}); else passed++;
      if (even) begin
        total++; if (p0_if.rdata !== exp_rdata) $display("FAIL alt%0d_rdata: got %h want %h", i, p0_if.rdata, exp_rdata); else passed++;
      end
    end
    idle_inputs();
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      p0_if.req  = 1'b1;
      p0_if.addr = 10'(10'h041 + 2 * i);
      settle();
      total++; if (p0_if.gnt !== 1'b1) $display("FAIL b2b%0d_gnt: got %b want 1", i, p0_if.gnt); else passed++;
      tick();
      total++; if ({p0_if.rvalid, p0_if.rdata} !== {1'b1, 32'h1000_0000 + 32'(2 * i + 1)}) $display("FAIL b2b%0d_read: rvalid=%b rdata=%h want 1/%h", i, p0_if.rvalid, p0_if.rdata, 32'h1000_0000 + 32'(2 * i + 1)); else passed++;
    end
    idle_inputs();
    tick();
    total++; if (p0_if.rvalid !== 1'b0) $display("FAIL b2b_end_rvalid: got %b want 0", p0_if.rvalid); else passed++;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    test_reset();
    test_p0_read();
    test_p1_write();
    test_starvation();
    test_lock();
    test_reset_mid();
    test_alternate();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
